// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serialiser.
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    // Bit-counter width: enough for 0..W-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return ($clog2(w) > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding register that queues the next frame while the current one shifts.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] word_reg;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            word_reg <= '0;
        end else if (load) begin
            word_reg <= d;
        end
    end

    assign q = word_reg;

endmodule

// File: rtl/piso_serialiser.sv
// Parallel-in serial-out serialiser with valid/ready load, one-word holding register
// and gapless back-to-back frames. Outputs are a registered view of the shift state.
module piso_serialiser
    import piso_pkg::*;
#(
    parameter int   W          = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         EN,
    input  logic [W-1:0] D,
    input  logic         LOAD_VALID,
    output logic         LOAD_READY,
    output logic         SOUT,
    output logic         SOUT_VALID,
    output logic         FRAME_START,
    output logic         FRAME_END,
    output logic         BUSY
);

    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    piso_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  shift_reg;
    logic          hold_full_reg;
    logic [W-1:0]  hold_word;

    logic          sout_reg;
    logic          sout_valid_reg;
    logic          frame_start_reg;
    logic          frame_end_reg;
    logic          busy_reg;

    logic          transfer;
    logic          at_last;
    logic          hold_load;
    logic          head_bit;
    logic [W-1:0]  shifted;

    assign LOAD_READY = EN & ~hold_full_reg;

    always_comb begin
        transfer  = LOAD_VALID & LOAD_READY;
        at_last   = (cnt_reg == CNT_LAST);
        // Only mid-frame transfers are parked; a boundary transfer bypasses the hold.
        hold_load = transfer & (state_reg == SHIFT) & ~at_last;
        head_bit  = LSB_FIRST ? shift_reg[0] : shift_reg[W-1];
        shifted   = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
    end

    piso_hold_reg #(.W(W)) u_hold (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .load    (hold_load),
        .d       (D),
        .q       (hold_word)
    );

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            shift_reg       <= '0;
            hold_full_reg   <= 1'b0;
            sout_reg        <= IDLE_LEVEL;
            sout_valid_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else if (EN) begin
            // Output stage presents the bit selected by the state before this edge.
            sout_reg        <= (state_reg == SHIFT) ? head_bit : IDLE_LEVEL;
            sout_valid_reg  <= (state_reg == SHIFT);
            frame_start_reg <= (state_reg == SHIFT) && (cnt_reg == '0);
            frame_end_reg   <= (state_reg == SHIFT) && at_last;
            busy_reg        <= (state_reg == SHIFT) || hold_full_reg;

            case (state_reg)
                IDLE: begin
                    if (transfer) begin
                        shift_reg <= D;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        shift_reg <= shifted;
                        cnt_reg   <= cnt_reg + CW'(1);
                        if (hold_load) begin
                            hold_full_reg <= 1'b1;
                        end
                    end else if (hold_full_reg) begin
                        shift_reg     <= hold_word;
                        cnt_reg       <= '0;
                        hold_full_reg <= 1'b0;
                    end else if (transfer) begin
                        shift_reg <= D;
                        cnt_reg   <= '0;
                    end else begin
                        shift_reg <= shifted;
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign SOUT        = sout_reg;
    assign SOUT_VALID  = sout_valid_reg;
    assign FRAME_START = frame_start_reg;
    assign FRAME_END   = frame_end_reg;
    assign BUSY        = busy_reg;

endmodule

// File: tb/tb_piso_serialiser.sv
// Bench for piso_serialiser: three instances (W=8 MSB-first, W=4 LSB-first, W=1) checked
// every cycle against a bit-queue model, plus directed vectors with literal expectations.
module tb_piso_serialiser;

    typedef struct packed {
        bit b;
        bit s;
        bit e;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] d [3];
    logic [2:0] lv;
    logic [2:0] rdy;
    logic [2:0] sout;
    logic [2:0] valid;
    logic [2:0] fs;
    logic [2:0] fe;
    logic [2:0] busy;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int WG   = (gi == 0) ? 8 : (gi == 1) ? 4 : 1;
            localparam bit LSBF = (gi == 1);

            piso_serialiser #(.W(WG), .LSB_FIRST(LSBF), .IDLE_LEVEL(1'b1)) dut (
                .CLK         (clk),
                .N_RESET     (rst_n),
                .EN          (en),
                .D           (d[gi][WG-1:0]),
                .LOAD_VALID  (lv[gi]),
                .LOAD_READY  (rdy[gi]),
                .SOUT        (sout[gi]),
                .SOUT_VALID  (valid[gi]),
                .FRAME_START (fs[gi]),
                .FRAME_END   (fe[gi]),
                .BUSY        (busy[gi])
            );

            // Model: accepted words become a stream of frame bits; each enabled edge
            // presents the oldest pending bit. More than one word pending = holding full.
            item_t q[$];
            item_t it;
            bit    take;
            logic  e_sout, e_valid, e_start, e_end, e_busy;

            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q.delete();
                    e_sout  = 1'b1;
                    e_valid = 1'b0;
                    e_start = 1'b0;
                    e_end   = 1'b0;
                    e_busy  = 1'b0;
                end else if (en) begin
                    take = lv[gi] && (q.size() <= WG);
                    if (q.size() > 0) begin
                        it      = q.pop_front();
                        e_sout  = it.b;
                        e_valid = 1'b1;
                        e_start = it.s;
                        e_end   = it.e;
                        e_busy  = 1'b1;
                    end else begin
                        e_sout  = 1'b1;
                        e_valid = 1'b0;
                        e_start = 1'b0;
                        e_end   = 1'b0;
                        e_busy  = 1'b0;
                    end
                    if (take) begin
                        for (int i = 0; i < WG; i++) begin
                            q.push_back('{b: (LSBF ? d[gi][i] : d[gi][WG-1-i]),
                                          s: (i == 0), e: (i == WG - 1)});
                        end
                    end
                end
            end

            always @(negedge clk) begin
                chk($sformatf("i%0d_sout", gi),  32'(sout[gi]),  32'(e_sout));
                chk($sformatf("i%0d_valid", gi), 32'(valid[gi]), 32'(e_valid));
                chk($sformatf("i%0d_start", gi), 32'(fs[gi]),    32'(e_start));
                chk($sformatf("i%0d_end", gi),   32'(fe[gi]),    32'(e_end));
                chk($sformatf("i%0d_busy", gi),  32'(busy[gi]),  32'(e_busy));
                chk($sformatf("i%0d_ready", gi), 32'(rdy[gi]),
                    32'(en && (q.size() <= WG)));
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int inst, input logic [7:0] word);
        d[inst]  = word;
        lv[inst] = 1'b1;
        $display("load inst%0d word %0h", inst, word);
    endtask

    logic [15:0] sb, sst, sen, srd, sva;
    int          vcount;

    task automatic clr();
        sb = '0; sst = '0; sen = '0; srd = '0; sva = '0;
    endtask

    task automatic grab(input int inst);
        sb  = {sb[14:0],  sout[inst]};
        sst = {sst[14:0], fs[inst]};
        sen = {sen[14:0], fe[inst]};
        srd = {srd[14:0], rdy[inst]};
        sva = {sva[14:0], valid[inst]};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        en    = 1'b1;
        lv    = '0;
        for (int i = 0; i < 3; i++) d[i] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_sout",  32'(sout[0]),  32'd1);
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_start", 32'(fs[0]),    32'd0);
        chk("rst_end",   32'(fe[0]),    32'd0);
        chk("rst_busy",  32'(busy[0]),  32'd0);
        chk("rst_ready", 32'(rdy[0]),   32'd1);
        #9 rst_n = 1'b1;
        repeat (2) step();

        // Single frame 8'hA5, MSB first.
        clr();
        start_load(0, 8'hA5);
        step();
        lv[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            grab(0);
        end
        chk("a5_bits",  32'(sb[7:0]),  32'hA5);
        chk("a5_start", 32'(sst[7:0]), 32'h80);
        chk("a5_end",   32'(sen[7:0]), 32'h01);
        step();
        chk("a5_idle_sout",  32'(sout[0]),  32'd1);
        chk("a5_idle_valid", 32'(valid[0]), 32'd0);
        chk("a5_idle_busy",  32'(busy[0]),  32'd0);
        repeat (2) step();

        // Back-to-back: 8'h3C then 8'hF0 loaded while bit 3 is on the line.
        clr();
        start_load(0, 8'h3C);
        step();
        lv[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            grab(0);
            if (k == 4) start_load(0, 8'hF0);
            if (k == 5) lv[0] = 1'b0;
        end
        chk("b2b_bits",  32'(sb),  32'h3CF0);
        chk("b2b_start", 32'(sst), 32'h8080);
        chk("b2b_end",   32'(sen), 32'h0101);
        chk("b2b_valid", 32'(sva), 32'hFFFF);
        chk("b2b_ready", 32'(srd), 32'hF1FF);
        step();
        chk("b2b_idle_valid", 32'(valid[0]), 32'd0);
        repeat (2) step();

        // Boundary bypass: 8'h81 transfers on the last-bit edge of 8'h5A.
        clr();
        start_load(0, 8'h5A);
        step();
        lv[0] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            grab(0);
            if (k == 7) start_load(0, 8'h81);
            if (k == 8) lv[0] = 1'b0;
        end
        chk("byp_bits",  32'(sb),  32'h5A81);
        chk("byp_start", 32'(sst), 32'h8080);
        chk("byp_valid", 32'(sva), 32'hFFFF);
        chk("byp_ready", 32'(srd), 32'hFFFF);
        repeat (3) step();

        // W=4 LSB first: 4'b0001 -> 1,0,0,0.
        clr();
        start_load(1, 8'h01);
        step();
        lv[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            grab(1);
        end
        chk("lsb_bits",  32'(sb[3:0]),  32'h8);
        chk("lsb_start", 32'(sst[3:0]), 32'h8);
        chk("lsb_end",   32'(sen[3:0]), 32'h1);
        repeat (2) step();

        // W=1: single bit 0 with both markers.
        start_load(2, 8'h00);
        step();
        lv[2] = 1'b0;
        step();
        chk("w1_sout",  32'(sout[2]),  32'd0);
        chk("w1_valid", 32'(valid[2]), 32'd1);
        chk("w1_start", 32'(fs[2]),    32'd1);
        chk("w1_end",   32'(fe[2]),    32'd1);
        repeat (2) step();

        // W=1 streaming 1,0,1 on consecutive edges.
        clr();
        start_load(2, 8'h01);
        step();
        start_load(2, 8'h00);
        step();
        grab(2);
        start_load(2, 8'h01);
        step();
        grab(2);
        lv[2] = 1'b0;
        step();
        grab(2);
        chk("w1_stream_bits",  32'(sb[2:0]),  32'h5);
        chk("w1_stream_valid", 32'(sva[2:0]), 32'h7);
        chk("w1_stream_ready", 32'(srd[2:0]), 32'h7);
        repeat (2) step();

        // EN stall for 3 cycles while bit 2 of 8'hC3 is on the line.
        clr();
        start_load(0, 8'hC3);
        step();
        lv[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            grab(0);
            if (k == 3) begin
                en = 1'b0;
                start_load(0, 8'hFF);
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("stall_sout",  32'(sout[0]),  32'd0);
                    chk("stall_valid", 32'(valid[0]), 32'd1);
                    chk("stall_start", 32'(fs[0]),    32'd0);
                    chk("stall_ready", 32'(rdy[0]),   32'd0);
                end
                lv[0] = 1'b0;
                en    = 1'b1;
            end
        end
        chk("stall_bits", 32'(sb[7:0]),  32'hC3);
        chk("stall_end",  32'(sen[7:0]), 32'h01);
        repeat (3) step();

        // Async reset at bit 5 of 8'h0F with 8'hAA held.
        start_load(0, 8'h0F);
        step();
        lv[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) start_load(0, 8'hAA);
            if (k == 2) lv[0] = 1'b0;
        end
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        chk("pre_rst_ready", 32'(rdy[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sout",  32'(sout[0]),  32'd1);
        chk("arst_valid", 32'(valid[0]), 32'd0);
        chk("arst_busy",  32'(busy[0]),  32'd0);
        chk("arst_ready", 32'(rdy[0]),   32'd1);
        #1 rst_n = 1'b1;
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (valid[0]) vcount++;
        end
        chk("post_rst_valid_count", 32'(vcount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
